// File: rtl/z_m_nibble_serial_addsub.sv
// Nibble-serial W-bit adder/subtractor.
// A single 4-bit carry-select stage is reused once per clock, LSB nibble first,
// with the inter-nibble carry held in a register. Subtraction is performed as
// a + ~b + ~c_in, so c_in acts as a borrow-in and c_out reads 1 when no borrow.

// 4-bit carry-select stage: both carry-in cases are computed, and c_in picks one.
module z_m_sca_stage (
   output logic [3:0] sum,
   output logic       c_out,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in
);

   logic [4:0] w_res_c0;
   logic [4:0] w_res_c1;

   assign w_res_c0       = {1'b0, a} + {1'b0, b};
   assign w_res_c1       = {1'b0, a} + {1'b0, b} + 5'd1;
   assign {c_out, sum}   = c_in ? w_res_c1 : w_res_c0;

endmodule

module z_m_nibble_serial_addsub #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 c_in,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 c_out,
   output logic                 overflow
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t           r_state;
   state_t           w_next;

   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;       // operand B already inverted for subtraction
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [W-1:0]     r_sum;
   logic             r_c_out;
   logic             r_ovf;
   logic             r_done;

   logic             w_accept;
   logic             w_last;
   logic [3:0]       w_stg_a;
   logic [3:0]       w_stg_b;
   logic [3:0]       w_stg_sum;
   logic             w_stg_cout;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
   assign w_stg_a  = r_a[4*r_idx +: 4];
   assign w_stg_b  = r_b[4*r_idx +: 4];

   z_m_sca_stage u_stage (
      .sum   (w_stg_sum),
      .c_out (w_stg_cout),
      .a     (w_stg_a),
      .b     (w_stg_b),
      .c_in  (r_carry)
   );

   // State register: IDLE / RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state: leave IDLE on start, return after the top nibble is processed.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs: busy follows RUN directly; result and done come from registers.
   always_comb begin
      busy     = (r_state == S_RUN);
      done     = r_done;
      sum      = r_sum;
      c_out    = r_c_out;
      overflow = r_ovf;
   end

   // Datapath: capture operands on accept, then one nibble per clock while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub ? ~c_in : c_in;
            r_idx   <= '0;
         end else if (r_state == S_RUN) begin
            r_sum[4*r_idx +: 4] <= w_stg_sum;
            r_carry             <= w_stg_cout;
            r_idx               <= r_idx + 1'b1;
            if (w_last) begin
               r_c_out <= w_stg_cout;
               // Same-signed operands producing a differently signed result.
               r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_stg_sum[3] != r_a[W-1]);
               r_done  <= 1'b1;
               r_idx   <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_z_m_nibble_serial_addsub.sv
// Testbench for z_m_nibble_serial_addsub (NIBBLES = 4, W = 16).
module tb_z_m_nibble_serial_addsub;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op_sub;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        c_out;
   logic        overflow;

   int vectors;
   int miscompares;

   z_m_nibble_serial_addsub #(.NIBBLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .c_out    (c_out),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic void ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                     input logic rc, input logic rsub,
                                     output logic [15:0] es, output logic eco,
                                     output logic eov);
      int u;
      int sr;
      int sa;
      int sb;
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (!rsub) begin
         u  = int'(ra) + int'(rb) + int'(rc);
         sr = sa + sb + int'(rc);
         eco = (u > 65535);
      end else begin
         u  = int'(ra) - int'(rb) - int'(rc);
         sr = sa - sb - int'(rc);
         eco = (u >= 0);
      end
      es  = 16'(u);
      eov = (sr > 32767) || (sr < -32768);
   endfunction

   // Issue one op at a negedge and wait (bounded) for done; returns at the done negedge.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic tsub, output int nbusy, output bit timed_out);
      int cyc;
      a = ta; b = tb_; c_in = tc; op_sub = tsub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      nbusy = 0;
      cyc   = 0;
      while (!done && cyc < 20) begin
         if (busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, sum, c_out, overflow} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
                  busy, done, sum, c_out, overflow);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [15:0] ta [6] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0000};
      logic [15:0] tb2[6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0007, 16'h0001, 16'h0000};
      logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [15:0] es;
      logic        eco, eov;
      int          nb;
      bit          to;
      for (int i = 0; i < 6; i++) begin
         ref_model(ta[i], tb2[i], tc[i], ts[i], es, eco, eov);
         do_op(ta[i], tb2[i], tc[i], ts[i], nb, to);
         vectors++;
         if (to || sum !== es || c_out !== eco || overflow !== eov) begin
            miscompares++;
            $display("FAIL directed_%0d: got sum=%h c_out=%b ovf=%b timeout=%0b, want sum=%h c_out=%b ovf=%b",
                     i, sum, c_out, overflow, to, es, eco, eov);
         end
         vectors++;
         if (nb != 4) begin
            miscompares++;
            $display("FAIL busy_len_%0d: got %0d busy cycles, want 4", i, nb);
         end
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_%0d: got done=%b busy=%b after done cycle, want 0 0", i, done, busy);
         end
         vectors++;
         if (sum !== es) begin
            miscompares++;
            $display("FAIL sum_hold_%0d: got %h, want %h", i, sum, es);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ra, rb, es;
      logic        rc, rs, eco, eov;
      int          nb;
      bit          to;
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rc = 1'($urandom);  rs = 1'($urandom);
         if (i % 8 == 0) rb = ~ra;
         ref_model(ra, rb, rc, rs, es, eco, eov);
         do_op(ra, rb, rc, rs, nb, to);
         vectors++;
         if (to || sum !== es || c_out !== eco || overflow !== eov || nb != 4) begin
            miscompares++;
            $display("FAIL random_%0d: %h %s %h c_in=%b got sum=%h c_out=%b ovf=%b busy=%0d, want sum=%h c_out=%b ovf=%b busy=4",
                     i, ra, rs ? "-" : "+", rb, rc, sum, c_out, overflow, nb, es, eco, eov);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] es, es3;
      logic        eco, eov, eco3, eov3;
      int          cyc;
      ref_model(16'h1111, 16'h2222, 1'b0, 1'b0, es, eco, eov);
      ref_model(16'h9000, 16'h1234, 1'b1, 1'b1, es3, eco3, eov3);
      a = 16'h1111; b = 16'h2222; c_in = 1'b0; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      // Second request while busy must be ignored.
      a = 16'hAAAA; b = 16'h5555; c_in = 1'b1; op_sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (!done || sum !== es || c_out !== eco || overflow !== eov) begin
         miscompares++;
         $display("FAIL start_while_busy: got done=%b sum=%h c_out=%b ovf=%b, want done=1 sum=%h c_out=%b ovf=%b",
                  done, sum, c_out, overflow, es, eco, eov);
      end
      // Request during the done cycle is accepted.
      a = 16'h9000; b = 16'h1234; c_in = 1'b1; op_sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL start_in_done: got done=%b busy=%b, want done=0 busy=1", done, busy);
      end
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (cyc != 5 || sum !== es3 || c_out !== eco3 || overflow !== eov3) begin
         miscompares++;
         $display("FAIL back_to_back: got %0d clocks sum=%h c_out=%b ovf=%b, want 5 clocks sum=%h c_out=%b ovf=%b",
                  cyc, sum, c_out, overflow, es3, eco3, eov3);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      logic [15:0] es;
      logic        eco, eov;
      int          nb;
      bit          to;
      bit          saw_done;
      a = 16'h1111; b = 16'h2222; c_in = 1'b0; op_sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, sum, c_out, overflow} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_midop: got busy=%b done=%b sum=%h c_out=%b ovf=%b, want all 0",
                  busy, done, sum, c_out, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL reset_discard: got done/busy after reset, want none");
      end
      ref_model(16'h1234, 16'h1111, 1'b0, 1'b0, es, eco, eov);
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, nb, to);
      vectors++;
      if (to || sum !== 16'h2345 || sum !== es || c_out !== eco || overflow !== eov) begin
         miscompares++;
         $display("FAIL after_reset_op: got sum=%h c_out=%b ovf=%b, want sum=2345 c_out=%b ovf=%b",
                  sum, c_out, overflow, eco, eov);
      end
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
